ow_reset_presence: RTL and testbench
====================================

# ow_reset_presence

Upstream link controller for the one-wire slave. It watches the shared bus for a master reset pulse and answers with a slave presence pulse. It then arms the command receiver (`cmd_reciever`) and asserts its `en_cmd_recieve` at the start of the first command bit slot. It releases that enable when the 8-bit command completes, times out, or a new reset pulse arrives. `clk` is 1 MHz, so 1 cycle = 1 µs, and all parameters are in cycles.

## Interface
Parameters:
- RESET_MIN, 480, consecutive synchronized-low cycles that qualify as a master reset pulse
- PRESENCE_WAIT, 30, cycles from synchronized bus release to the start of the presence pulse
- PRESENCE_LEN, 120, cycles the block drives the bus low for presence
- CMD_TIMEOUT, 569, maximum cycles `en_cmd_recieve` stays high
- CNT_W, 10, counter width; must hold max(RESET_MIN, CMD_TIMEOUT)

Ports:
- clk  in  1  system clock, 1 MHz
- rst  in  1  synchronous, active-high reset
- bus  inout  1  open-drain one-wire line; the block drives only 0 or Z
- done_recieving  in  1  from the command receiver; may be sticky-high
- en_cmd_recieve  out  1  enable to the command receiver
- presence  out  1  high exactly while the block drives the bus low
- reset_seen  out  1  single-cycle pulse when a reset pulse qualifies

## Operation
- Bus input passes through a 2-flop synchronizer giving `bus_s`. Both flops reset to 1.
- Bus drive: the bus is 0 when `presence`=1, otherwise Z.
- Low counter `low_cnt`:
  - increments while `bus_s`=0;
  - clears when `bus_s`=1;
  - saturates at RESET_MIN;
  - is held cleared in WAIT_PRES, PRESENCE and RECOVER, so the block's own drive is never counted.
- Reset qualification: active in IDLE, ARMED and RECEIVE. When `bus_s`=0 and `low_cnt`=RESET_MIN-1:
  - next state is RST_LOW;
  - `reset_seen` is 1 for one cycle;
  - `en_cmd_recieve` is 0 from the same cycle.
- `done_recieving` is edge-detected with a registered copy. Only the 0→1 transition counts, which tolerates a sticky receiver.
- FSM:
  - IDLE: wait for reset qualification.
  - RST_LOW: wait for `bus_s`=1, then go to WAIT_PRES with the phase counter cleared.
  - WAIT_PRES: count PRESENCE_WAIT cycles, then go to PRESENCE.
  - PRESENCE: `presence`=1 for exactly PRESENCE_LEN cycles, then go to RECOVER.
  - RECOVER: bus released; wait for `bus_s`=1, then go to ARMED.
  - ARMED: on a `bus_s` falling edge (1→0 between consecutive cycles), go to RECEIVE with `en_cmd_recieve`=1 and the phase counter cleared.
  - RECEIVE: `en_cmd_recieve` held at 1. Exit to IDLE with enable 0 on whichever comes first:
    - a `done_recieving` rising edge;
    - the phase counter reaching CMD_TIMEOUT-1.
- Priority in RECEIVE: reset qualification beats done, and done beats timeout. If both happen in the same cycle, the next state is RST_LOW.
- `rst` mid-operation: on the next edge the state is IDLE, the bus is released, all counters are 0, and all outputs are 0.

## Timing
- Reset values: `en_cmd_recieve`=0, `presence`=0, `reset_seen`=0, bus=Z, state=IDLE, synchronizer=1, edge-detect register=0.
- All outputs are registered. The synchronizer adds 2 cycles of pin-to-`bus_s` latency.
- Reset detection: `reset_seen` is high in cycle P+RESET_MIN+2, where P is the first cycle the pin reads low.
- Presence timing, with R = the first cycle `bus_s`=1 in RST_LOW:
  - `presence` rises at R+PRESENCE_WAIT;
  - `presence` falls at R+PRESENCE_WAIT+PRESENCE_LEN.
- Enable: `en_cmd_recieve` rises 3 cycles after the pin falling edge in ARMED (2 synchronizer + 1 register).
- Timeout: enable width is at most CMD_TIMEOUT cycles.
- Done: enable falls the cycle after a registered `done_recieving` rising edge.
- A low pulse shorter than RESET_MIN never produces `reset_seen`.

## Test plan
- Pin low 500 cycles, then released → `reset_seen` pulses once at cycle 482. `presence` is high for 120 cycles starting 30 cycles after `bus_s` returns high, and the bus reads 0 throughout.
- Pin low 400 cycles → no `reset_seen`, no `presence`, state stays IDLE.
- After presence, pin falls at cycle T → `en_cmd_recieve` rises at T+3. `done_recieving` rises at T+570 → enable falls one cycle later, state IDLE.
- After presence, pin falls and `done_recieving` stays 0 → enable stays high for exactly 569 cycles, then drops.
- In RECEIVE, pin held low 480+ cycles → enable drops in the same cycle `reset_seen` pulses, and a new presence pulse follows.
- `rst` asserted on cycle 50 of PRESENCE → next cycle `presence`=0, bus=Z, all outputs 0. A subsequent 500-cycle reset pulse is handled normally.

Source files
------------

// File: rtl/ow_reset_presence.sv
// One-wire slave link controller: qualifies a master reset pulse, answers with a
// presence pulse, then enables the command receiver for one command.
module ow_reset_presence #(
    parameter int RESET_MIN     = 480,
    parameter int PRESENCE_WAIT = 30,
    parameter int PRESENCE_LEN  = 120,
    parameter int CMD_TIMEOUT   = 569,
    parameter int CNT_W         = 10
) (
    input  logic clk,
    input  logic rst,
    inout  logic bus,
    input  logic done_recieving,
    output logic en_cmd_recieve,
    output logic presence,
    output logic reset_seen
);

    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        WAIT_PRES,
        PRESENCE,
        RECOVER,
        ARMED,
        RECEIVE
    } state_t;

    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RESET_MIN - 1);
    localparam logic [CNT_W-1:0] LOW_MAX   = CNT_W'(RESET_MIN);
    // RST_LOW's release cycle counts as the first wait cycle
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PRESENCE_WAIT - 2);
    localparam logic [CNT_W-1:0] PRES_LAST = CNT_W'(PRESENCE_LEN - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(CMD_TIMEOUT - 1);

    state_t           state, next_state;
    logic             sync1, bus_s, bus_prev, done_q;
    logic [CNT_W-1:0] low_cnt, phase_cnt;
    logic             listening, self_drive, qual, done_rise, bus_fall;
    logic             en_d, presence_d, reset_seen_d;

    assign bus = presence ? 1'b0 : 1'bz;

    always_comb begin
        listening  = (state == IDLE) || (state == ARMED) || (state == RECEIVE);
        self_drive = (state == WAIT_PRES) || (state == PRESENCE) || (state == RECOVER);
        qual       = listening && !bus_s && (low_cnt == LOW_LAST);
        done_rise  = done_recieving && !done_q;
        bus_fall   = bus_prev && !bus_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sync1          <= 1'b1;
            bus_s          <= 1'b1;
            bus_prev       <= 1'b1;
            done_q         <= 1'b0;
            low_cnt        <= '0;
            phase_cnt      <= '0;
            en_cmd_recieve <= 1'b0;
            presence       <= 1'b0;
            reset_seen     <= 1'b0;
        end else begin
            state    <= next_state;
            sync1    <= bus;
            bus_s    <= sync1;
            bus_prev <= bus_s;
            done_q   <= done_recieving;
            if (self_drive || bus_s)
                low_cnt <= '0;
            else if (low_cnt != LOW_MAX)
                low_cnt <= low_cnt + CNT_W'(1);
            if (next_state != state)
                phase_cnt <= '0;
            else
                phase_cnt <= phase_cnt + CNT_W'(1);
            en_cmd_recieve <= en_d;
            presence       <= presence_d;
            reset_seen     <= reset_seen_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (qual) next_state = RST_LOW;
            RST_LOW:   if (bus_s) next_state = WAIT_PRES;
            WAIT_PRES: if (phase_cnt == WAIT_LAST) next_state = PRESENCE;
            PRESENCE:  if (phase_cnt == PRES_LAST) next_state = RECOVER;
            RECOVER:   if (bus_s) next_state = ARMED;
            ARMED: begin
                if (qual)          next_state = RST_LOW;
                else if (bus_fall) next_state = RECEIVE;
            end
            RECEIVE: begin
                // a new reset beats done, done beats timeout
                if (qual)                         next_state = RST_LOW;
                else if (done_rise)               next_state = IDLE;
                else if (phase_cnt == TMO_LAST)   next_state = IDLE;
            end
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        en_d         = (next_state == RECEIVE);
        presence_d   = (next_state == PRESENCE);
        reset_seen_d = qual;
    end

endmodule

// File: tb/tb_ow_reset_presence.sv
// Directed bench for ow_reset_presence: a timeline model of the link protocol
// checked every cycle, plus literal edge-cycle expectations per scenario.
module tb_ow_reset_presence;

    localparam int RESET_MIN     = 480;
    localparam int PRESENCE_WAIT = 30;
    localparam int PRESENCE_LEN  = 120;
    localparam int CMD_TIMEOUT   = 569;
    localparam int HMAX          = 8192;

    logic clk = 1'b0;
    logic rst, master_low, done;
    logic en_cmd_recieve, presence, reset_seen;
    wire  bus_w;

    assign bus_w = master_low ? 1'b0 : 1'bz;
    pullup (bus_w);

    ow_reset_presence #(
        .RESET_MIN    (RESET_MIN),
        .PRESENCE_WAIT(PRESENCE_WAIT),
        .PRESENCE_LEN (PRESENCE_LEN),
        .CMD_TIMEOUT  (CMD_TIMEOUT),
        .CNT_W        (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_w),
        .done_recieving(done),
        .en_cmd_recieve(en_cmd_recieve),
        .presence      (presence),
        .reset_seen    (reset_seen)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: the link lives in one of these protocol phases; timing comes from timestamps.
    typedef enum {M_LISTEN, M_HELD, M_ANSWER, M_WAITBIT, M_CMD} mphase_t;
    mphase_t mph = M_LISTEN;
    bit line_h [0:HMAX-1];
    bit done_h [0:HMAX-1];
    int last_rst = 0;
    int run = 0;
    int r_cyc = 0;
    int en_start = 0;
    logic exp_rs = 1'b0, exp_en = 1'b0, exp_pres = 1'b0;

    function automatic bit synced(input int x);
        if (x < 2 || x - 2 <= last_rst) return 1'b1;
        return line_h[x-2];
    endfunction

    // Edge recorders taken from the DUT outputs, for the literal checks.
    logic rs_p = 1'b0, en_p = 1'b0, pres_p = 1'b0;
    int rs_rise = -1, en_rise = -1, en_fall = -1, pres_rise = -1, pres_fall = -1;
    int rs_count = 0, pres_count = 0;

    always @(negedge clk) begin
        bit line_now, l, lp, dprev, drise, qual;
        if (cyc >= 1 && cyc < HMAX) begin
            line_now = !(master_low || exp_pres);
            check("reset_seen", {31'b0, reset_seen}, {31'b0, exp_rs});
            check("en_cmd_recieve", {31'b0, en_cmd_recieve}, {31'b0, exp_en});
            check("presence", {31'b0, presence}, {31'b0, exp_pres});
            check("bus", {31'b0, bus_w}, {31'b0, line_now});

            if (reset_seen && !rs_p) begin rs_rise = cyc; rs_count++; end
            if (en_cmd_recieve && !en_p) en_rise = cyc;
            if (!en_cmd_recieve && en_p) en_fall = cyc;
            if (presence && !pres_p) begin pres_rise = cyc; pres_count++; end
            if (!presence && pres_p) pres_fall = cyc;
            rs_p = reset_seen; en_p = en_cmd_recieve; pres_p = presence;

            line_h[cyc] = line_now;
            done_h[cyc] = done;
            if (rst) begin
                mph = M_LISTEN; run = 0; last_rst = cyc;
                exp_rs = 1'b0; exp_en = 1'b0; exp_pres = 1'b0;
            end else begin
                l     = synced(cyc);
                lp    = synced(cyc - 1);
                dprev = (cyc - 1 > last_rst) ? done_h[cyc-1] : 1'b0;
                drise = done && !dprev;
                run   = l ? 0 : run + 1;
                if (mph == M_ANSWER) run = 0;
                qual  = (mph inside {M_LISTEN, M_WAITBIT, M_CMD}) && run == RESET_MIN;
                case (mph)
                    M_LISTEN:  if (qual) mph = M_HELD;
                    M_HELD:    if (l) begin r_cyc = cyc; mph = M_ANSWER; end
                    M_ANSWER:  if (cyc >= r_cyc + PRESENCE_WAIT + PRESENCE_LEN && l) mph = M_WAITBIT;
                    M_WAITBIT: begin
                        if (qual) mph = M_HELD;
                        else if (lp && !l) begin mph = M_CMD; en_start = cyc + 1; end
                    end
                    M_CMD: begin
                        if (qual) mph = M_HELD;
                        else if (drise) mph = M_LISTEN;
                        else if (cyc + 1 - en_start == CMD_TIMEOUT) mph = M_LISTEN;
                    end
                    default: mph = M_LISTEN;
                endcase
                exp_rs   = qual;
                exp_en   = (mph == M_CMD);
                exp_pres = (mph == M_ANSWER) && (cyc + 1 >= r_cyc + PRESENCE_WAIT)
                           && (cyc + 1 < r_cyc + PRESENCE_WAIT + PRESENCE_LEN);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int rs0, pr0;
        rst = 1'b1; master_low = 1'b0; done = 1'b0;
        wait_until(3);
        check("reset en", {31'b0, en_cmd_recieve}, 0);
        check("reset presence", {31'b0, presence}, 0);
        rst = 1'b0;

        // A: 500-cycle reset pulse from cycle 20
        wait_until(20);  master_low = 1'b1;
        wait_until(520); master_low = 1'b0;
        wait_until(720);
        check("A reset_seen cycle", rs_rise, 502);
        check("A reset_seen count", rs_count, 1);
        check("A presence rise", pres_rise, 552);
        check("A presence fall", pres_fall, 672);

        // B: command bit slot at 720, done rises at 1290
        master_low = 1'b1;
        wait_until(730);  master_low = 1'b0;
        wait_until(1290); done = 1'b1;
        wait_until(1300); done = 1'b0;
        wait_until(1320);
        check("B enable rise", en_rise, 723);
        check("B enable fall", en_fall, 1291);

        // C: re-arm, then let the command time out
        master_low = 1'b1;
        wait_until(1820); master_low = 1'b0;
        wait_until(2020); master_low = 1'b1;
        wait_until(2030); master_low = 1'b0;
        wait_until(2620);
        check("C enable rise", en_rise, 2023);
        check("C enable fall", en_fall, 2592);
        check("C enable width", en_fall - en_rise, CMD_TIMEOUT);

        // D: 400-cycle low is too short to qualify
        rs0 = rs_count; pr0 = pres_count;
        wait_until(2640); master_low = 1'b1;
        wait_until(3040); master_low = 1'b0;
        wait_until(3240);
        check("D no reset_seen", rs_count - rs0, 0);
        check("D no presence", pres_count - pr0, 0);

        // E: reset pulse while receiving a command
        wait_until(3260); master_low = 1'b1;
        wait_until(3760); master_low = 1'b0;
        wait_until(3960); master_low = 1'b1;
        wait_until(4460); master_low = 1'b0;
        wait_until(4680);
        check("E enable rise", en_rise, 3963);
        check("E reset_seen cycle", rs_rise, 4442);
        check("E enable fall", en_fall, 4442);
        check("E presence rise", pres_rise, 4492);
        check("E presence fall", pres_fall, 4612);

        // F: rst on the 50th presence cycle, then a normal reset pulse
        master_low = 1'b1;
        wait_until(5180); master_low = 1'b0;
        wait_until(5261); rst = 1'b1;
        wait_until(5262); rst = 1'b0;
        check("F presence rise", pres_rise, 5212);
        check("F presence cleared", {31'b0, presence}, 0);
        wait_until(5263);
        check("F presence fall", pres_fall, 5262);
        wait_until(5280); master_low = 1'b1;
        wait_until(5780); master_low = 1'b0;
        wait_until(6000);
        check("F reset_seen cycle", rs_rise, 5762);
        check("F presence rise 2", pres_rise, 5812);
        check("F presence fall 2", pres_fall, 5932);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
